// File: rtl/disp_seq_pkg.sv
// Shared types and constants for the display frame sequencer.
// Imported by disp_tick_gen and disp_frame_seq.
package disp_seq_pkg;

    typedef enum logic [1:0] {
        MODE_LOOP     = 2'd0,
        MODE_ONESHOT  = 2'd1,
        MODE_PINGPONG = 2'd2,
        MODE_RSVD     = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    localparam int PKG_DATA_W = 64;

    // All segments off on the active-low 7-segment driver.
    localparam logic [PKG_DATA_W-1:0] BLANK_VALUE = {PKG_DATA_W{1'b1}};

    // Index width with a floor of one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/disp_tick_gen.sv
// Clock-enable prescaler: one-cycle tick every DIV_FAST or DIV_SLOW clocks.
// A rate switch that strands the count above the new limit wraps silently.
module disp_tick_gen
    import disp_seq_pkg::*;
#(
    parameter int unsigned DIV_FAST = 2**25,
    parameter int unsigned DIV_SLOW = 2**27
) (
    input  logic clk,
    input  logic rstn,
    input  logic rate_sel,
    input  logic clr,
    output logic tick
);

    localparam int unsigned DIV_MAX = (DIV_FAST > DIV_SLOW) ? DIV_FAST : DIV_SLOW;
    localparam int CW = idx_w(int'(DIV_MAX));

    localparam logic [CW-1:0] LIM_F = CW'(DIV_FAST - 1);
    localparam logic [CW-1:0] LIM_S = CW'(DIV_SLOW - 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] lim;

    assign lim  = rate_sel ? LIM_S : LIM_F;
    assign tick = (cnt == lim);

    // Count up to the active limit; reaching or overshooting it wraps to 0.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (clr || (cnt >= lim)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/disp_frame_seq.sv
// Frame-memory animation sequencer and display-source mux for the 7-seg bus.
// Optional blanking input is enabled by defining DISP_FRAME_SEQ_BLANK_EN.
module disp_frame_seq
    import disp_seq_pkg::*;
#(
    parameter int              DATA_W        = 64,
    parameter int              NUM_FRAMES    = 16,
    parameter int              NUM_SRC       = 4,
    parameter int unsigned     DIV_FAST      = 2**25,
    parameter int unsigned     DIV_SLOW      = 2**27,
    parameter logic [DATA_W-1:0] RESET_PATTERN = 'h1,
    parameter string           INIT_FILE     = ""
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          en,
    input  logic                          rate_sel,
    input  logic [1:0]                    mode,
    input  logic                          step,
    input  logic                          restart,
    input  logic                          anim_sel,
`ifdef DISP_FRAME_SEQ_BLANK_EN
    input  logic                          blank,
`endif
    input  logic [idx_w(NUM_SRC)-1:0]     src_sel,
    input  logic [NUM_SRC*DATA_W-1:0]     src_data,
    input  logic                          frame_we,
    input  logic [idx_w(NUM_FRAMES)-1:0]  frame_waddr,
    input  logic [DATA_W-1:0]             frame_wdata,
    output logic [DATA_W-1:0]             disp_data,
    output logic [idx_w(NUM_FRAMES)-1:0]  frame_idx,
    output logic                          done,
    output logic                          tick
);

    localparam int AW = idx_w(NUM_FRAMES);
    localparam int SW = idx_w(NUM_SRC);

    localparam logic [AW-1:0] LAST   = AW'(NUM_FRAMES - 1);
    localparam logic [AW:0]   NF_EXT = (AW+1)'(NUM_FRAMES);

    logic [DATA_W-1:0] mem [NUM_FRAMES];

    logic [1:0]        mode_q;
    dir_e              dir;

    logic              adv;
    logic              mode_chg;
    logic              pp_entry;
    logic              done_eff;
    dir_e              dir_eff;
    logic [AW-1:0]     idx_nxt;
    dir_e              dir_nxt;
    logic              done_nxt;
    logic              wr_ok;
    logic [DATA_W-1:0] src_ch;

    disp_tick_gen #(
        .DIV_FAST (DIV_FAST),
        .DIV_SLOW (DIV_SLOW)
    ) u_tick (
        .clk      (clk),
        .rstn     (rstn),
        .rate_sel (rate_sel),
        .clr      (restart),
        .tick     (tick)
    );

    assign wr_ok = ({1'b0, frame_waddr} < NF_EXT);

    // Frame memory write port; out-of-range addresses are dropped.
    always_ff @(posedge clk) begin
        if (frame_we && wr_ok) begin
            mem[frame_waddr] <= frame_wdata;
        end
    end

    // Next-index logic for the three playback modes.
    always_comb begin
        adv      = (en & tick) | step;
        mode_chg = (mode != mode_q);
        pp_entry = mode_chg && (mode == MODE_PINGPONG);
        done_eff = done & ~mode_chg;
        dir_eff  = dir;
        if (pp_entry) begin
            dir_eff = (frame_idx == LAST) ? DIR_DOWN : DIR_UP;
        end
        idx_nxt  = frame_idx;
        dir_nxt  = dir_eff;
        done_nxt = done_eff;
        if (adv) begin
            unique case (1'b1)
                (mode == MODE_ONESHOT): begin
                    if (!done_eff) begin
                        if (frame_idx == LAST) begin
                            done_nxt = 1'b1;
                        end else begin
                            idx_nxt  = frame_idx + 1'b1;
                            done_nxt = ((frame_idx + 1'b1) == LAST);
                        end
                    end
                end
                (mode == MODE_PINGPONG): begin
                    if (LAST != '0) begin
                        if (dir_eff == DIR_UP) begin
                            if (frame_idx == LAST) begin
                                idx_nxt = frame_idx - 1'b1;
                                dir_nxt = DIR_DOWN;
                            end else begin
                                idx_nxt = frame_idx + 1'b1;
                            end
                        end else begin
                            if (frame_idx == '0) begin
                                idx_nxt = frame_idx + 1'b1;
                                dir_nxt = DIR_UP;
                            end else begin
                                idx_nxt = frame_idx - 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    idx_nxt = (frame_idx == LAST) ? '0 : frame_idx + 1'b1;
                end
            endcase
        end
    end

    // Sequencer state; restart overrides any advance in the same cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            frame_idx <= '0;
            dir       <= DIR_UP;
            done      <= 1'b0;
            mode_q    <= MODE_LOOP;
        end else begin
            mode_q <= mode;
            if (restart) begin
                frame_idx <= '0;
                dir       <= DIR_UP;
                done      <= 1'b0;
            end else begin
                frame_idx <= idx_nxt;
                dir       <= dir_nxt;
                done      <= done_nxt;
            end
        end
    end

    // Live channel pick; selects past the last channel fall back to channel 0.
    always_comb begin
        src_ch = src_data[0 +: DATA_W];
        for (int k = 1; k < NUM_SRC; k++) begin
            if (src_sel == SW'(k)) begin
                src_ch = src_data[k*DATA_W +: DATA_W];
            end
        end
    end

`ifdef DISP_FRAME_SEQ_BLANK_EN
    localparam logic [DATA_W-1:0] BLANK_FULL = {DATA_W{BLANK_VALUE[0]}};
`endif

    // Registered display bus, refreshed every cycle even while paused.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            disp_data <= RESET_PATTERN;
`ifdef DISP_FRAME_SEQ_BLANK_EN
        end else if (blank) begin
            disp_data <= BLANK_FULL;
`endif
        end else if (anim_sel) begin
            disp_data <= mem[frame_idx];
        end else begin
            disp_data <= src_ch;
        end
    end

endmodule
